multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Moore-style main controller for the 16-bit multi-cycle processor.
- Sequences the datapath (PC, IR, A/B, ALUOut and MDR simple registers, register file, ALU, memory) through fetch, decode, execute, memory and writeback steps.
- Decodes a 4-bit opcode, waits on a memory-ready handshake, and keeps a retired-fetch counter plus sticky halt/illegal flags for the debug bench.

Parameters:
- CNT_W, 16, width of InstrCount.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Run  input  1  start request; sampled only in IDLE.
- Opcode  input  4  IR[15:12]; stable from DECODE until the instruction returns to FETCH.
- Zero  input  1  ALU zero flag, combinational from the current ALU operation.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  load the PC (already gated for branches).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load the IR.
- MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  destination select: 1 = rd (R-type), 0 = rt.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = const 2, 10 = sign-extended imm, 11 = imm<<1.
- ALUOp  output  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR.
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- Halted  output  1  controller is in HALT.
- IllegalOp  output  1  sticky; an undefined opcode was decoded.
- State  output  4  current state encoding.
- InstrCount  output  CNT_W  count of completed fetches.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type); 4 ADDI; 5 LW; 6 SW; 7 BEQ; 8 BNE; 9 J; F HALT; A–E illegal.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WB 7, MEM_WR 8, ALU_WB 9, BRANCH 10, JUMP 11, HALT 12.
- Outputs are decoded from State only, except PCWrite and IRWrite (MemReady in FETCH) and PCWrite in BRANCH (Zero). Any output not listed for a state is 0.
- Reset: State = IDLE; all control outputs 0; InstrCount = 0; IllegalOp = 0. RST wins over every other input, including mid-access; a MEM_WR in progress deasserts MemWrite the cycle after RST is sampled.
- IDLE: go to FETCH when Run = 1, else stay.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = ADD, PCSource = 00.
  - MemReady = 1: IRWrite = 1, PCWrite = 1, InstrCount += 1 (wraps to 0 after all ones), next DECODE.
  - MemReady = 0: stay in FETCH, hold requests.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = ADD (precomputes the branch target into ALUOut). Next state by opcode:
  - 0–3 → EXEC_R; 4 → EXEC_I; 5, 6 → ADDR; 7, 8 → BRANCH; 9 → JUMP; F → HALT.
  - A–E → HALT, and IllegalOp is set on this edge.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = {0, Opcode[1:0]}; next ALU_WB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = ADD; next ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0, RegDst = 1 if Opcode ≤ 3 else 0; next FETCH.
- ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = ADD; next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead = 1, IorD = 1; stay until MemReady = 1, then MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0; next FETCH.
- MEM_WR: MemWrite = 1, IorD = 1; stay until MemReady = 1, then FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = SUB, PCSource = 01.
  - PCWrite = Zero for BEQ, ~Zero for BNE.
  - Next FETCH.
- JUMP: PCSource = 10, PCWrite = 1; next FETCH.
- HALT: Halted = 1; absorbing until RST; Run ignored. IllegalOp is held until RST.
- Run is ignored outside IDLE; deasserting it mid-program does not stop execution.
- Latency without wait states:
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - J: 3 cycles.
  - Each MemReady = 0 cycle adds one cycle in FETCH, MEM_RD or MEM_WR.

Test Plan:
- RST = 1 for 2 cycles, then Run = 1, MemReady = 1, Opcode = 0 → States 0,1,2,3,9,1; ALUOp = 000 in EXEC_R; RegWrite = 1 and RegDst = 1 in ALU_WB; InstrCount = 1 after the first FETCH.
- LW (Opcode = 5), MemReady low for 3 cycles in MEM_RD → State 6 held 4 cycles with MemRead = 1, IorD = 1; then MEM_WB with MemtoReg = 1, RegWrite = 1.
- BEQ with Zero = 1 → PCWrite = 1, PCSource = 01 in BRANCH. BNE with Zero = 1 → PCWrite = 0. Both return to FETCH.
- Opcode = C → DECODE → HALT; IllegalOp = 1, Halted = 1; Run toggling for 10 cycles leaves State = 12.
- SW in MEM_WR with MemReady = 0, then RST = 1 → next cycle State = 0, MemWrite = 0, InstrCount = 0, IllegalOp = 0.
- Preload 0xFFFF fetches (or CNT_W = 4 with 15 fetches), then one more fetch → InstrCount wraps to 0 on the fetch completion edge.

Source files
------------

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control_unit
// Brief  : Moore main controller for the 16-bit multi-cycle processor.
// Rev    : 1.0
// ============================================================================
module multicycle_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Run,
    input  logic [3:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        EXEC_I = 4'd4,
        ADDR   = 4'd5,
        MEM_RD = 4'd6,
        MEM_WB = 4'd7,
        MEM_WR = 4'd8,
        ALU_WB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [2:0]       c_alu_add   = 3'b000;
    localparam logic [2:0]       c_alu_sub   = 3'b001;
    localparam logic [1:0]       c_srcb_reg  = 2'b00;
    localparam logic [1:0]       c_srcb_two  = 2'b01;
    localparam logic [1:0]       c_srcb_imm  = 2'b10;
    localparam logic [1:0]       c_srcb_ims  = 2'b11;
    localparam logic [1:0]       c_pc_aluout = 2'b01;
    localparam logic [1:0]       c_pc_jump   = 2'b10;
    localparam logic [3:0]       c_op_lw     = 4'h5;
    localparam logic [3:0]       c_op_beq    = 4'h7;
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_illegal;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_instr_count <= '0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Run) r_state <= FETCH;
                end
                FETCH: begin
                    if (MemReady) begin
                        r_state       <= DECODE;
                        r_instr_count <= r_instr_count + c_cnt_one;
                    end
                end
                DECODE: begin
                    case (Opcode)
                        4'h0, 4'h1, 4'h2, 4'h3: r_state <= EXEC_R;
                        4'h4:                   r_state <= EXEC_I;
                        4'h5, 4'h6:             r_state <= ADDR;
                        4'h7, 4'h8:             r_state <= BRANCH;
                        4'h9:                   r_state <= JUMP;
                        4'hF:                   r_state <= HALT;
                        default: begin
                            // Undefined opcodes park the core and leave a sticky marker.
                            r_state   <= HALT;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                EXEC_R, EXEC_I: r_state <= ALU_WB;
                ADDR: begin
                    r_state <= (Opcode == c_op_lw) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    if (MemReady) r_state <= MEM_WB;
                end
                MEM_WR: begin
                    if (MemReady) r_state <= FETCH;
                end
                MEM_WB, ALU_WB, BRANCH, JUMP: r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pure state decode; only the PC/IR strobes look at MemReady and Zero.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = c_srcb_reg;
        ALUOp    = c_alu_add;
        PCSource = 2'b00;
        Halted   = 1'b0;
        case (r_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = c_srcb_two;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = c_srcb_ims;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_reg;
                ALUOp   = {1'b0, Opcode[1:0]};
            end
            EXEC_I, ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = (Opcode <= 4'h3);
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = c_srcb_reg;
                ALUOp    = c_alu_sub;
                PCSource = c_pc_aluout;
                PCWrite  = (Opcode == c_op_beq) ? Zero : ~Zero;
            end
            JUMP: begin
                PCSource = c_pc_jump;
                PCWrite  = 1'b1;
            end
            HALT: begin
                Halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign State      = r_state;
    assign InstrCount = r_instr_count;
    assign IllegalOp  = r_illegal;

endmodule
`default_nettype wire
